// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receive path: slot geometry and parameter defaults.
// No logic, no latency, no flow control.
package i2s_pkg;

    localparam int SLOTS_PER_HALF        = 32;
    localparam int COUNT_W               = 5;
    localparam int DEFAULT_WORD_W        = 24;
    localparam int DEFAULT_BCK_DIV_LOG2  = 3;

endpackage : i2s_pkg

// File: rtl/i2s_clkgen.sv
// Free-running mck divider producing sck/bck/lrck/count and the bck-rise sample strobe.
// Outputs are divider flop bits (zero latency after the edge); free-running, no backpressure.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCK_DIV_LOG2 = DEFAULT_BCK_DIV_LOG2
) (
    input  logic               mck,
    input  logic               reset,
    output logic               sck,
    output logic               bck,
    output logic               lrck,
    output logic [COUNT_W-1:0] count,
    output logic               sample_en
);

    localparam int L     = BCK_DIV_LOG2;
    localparam int DIV_W = L + $clog2(SLOTS_PER_HALF) + 1;

    // Phase just before bck rises: low L bits = 0111..1.
    localparam logic [L-1:0] SAMPLE_PHASE = {1'b0, {(L-1){1'b1}}};

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + DIV_W'(1);
    end

    always_ff @(posedge mck or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign sck       = div_q[0];
    assign bck       = div_q[L-1];
    assign count     = div_q[L+4:L];
    assign lrck      = div_q[L+5];
    assign sample_en = (div_q[L-1:0] == SAMPLE_PHASE);

endmodule : i2s_clkgen

// File: rtl/i2s_rx_core.sv
// I2S master clocking plus MSB-first deserializer; word lands on the LSB-sampling bck rise (0 mck latency).
// No backpressure: data_rdy is a one-mck strobe and each new word overwrites data_out.
module i2s_rx_core
    import i2s_pkg::*;
#(
    parameter int WORD_W       = DEFAULT_WORD_W,
    parameter int BCK_DIV_LOG2 = DEFAULT_BCK_DIV_LOG2
) (
    input  logic               mck,
    input  logic               reset,
    input  logic               data_in,
    output logic               sck,
    output logic               bck,
    output logic               lrck,
    output logic [WORD_W-1:0]  data_out,
    output logic [COUNT_W-1:0] count,
    output logic               data_rdy
);

    // Philips framing: MSB in slot 1, so the LSB arrives in slot WORD_W.
    localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(WORD_W);

    logic              sample_en;
    logic [WORD_W-1:0] shifted;
    logic              word_done;

    logic [WORD_W-1:0] shreg_q,    shreg_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              data_rdy_q, data_rdy_d;

    i2s_clkgen #(
        .BCK_DIV_LOG2 (BCK_DIV_LOG2)
    ) u_clkgen (
        .mck       (mck),
        .reset     (reset),
        .sck       (sck),
        .bck       (bck),
        .lrck      (lrck),
        .count     (count),
        .sample_en (sample_en)
    );

    always_comb begin
        shifted    = (shreg_q << 1) | WORD_W'(data_in);
        word_done  = sample_en && (count == LAST_SLOT);
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        data_rdy_d = word_done;
        if (sample_en) begin
            shreg_d = shifted;
        end
        if (word_done) begin
            data_out_d = shifted;
        end
    end

    always_ff @(posedge mck or negedge reset) begin
        if (!reset) begin
            shreg_q    <= '0;
            data_out_q <= '0;
            data_rdy_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            data_rdy_q <= data_rdy_d;
        end
    end

    assign data_out = data_out_q;
    assign data_rdy = data_rdy_q;

endmodule : i2s_rx_core

// File: tb/tb_i2s_rx_core.sv
// Bench for i2s_rx_core: default (24-bit, mck/8) and narrow (16-bit, mck/4) instances on one mck.
module tb_i2s_rx_core;

    localparam int LA = 3;
    localparam int WA = 24;
    localparam int LB = 2;
    localparam int WB = 16;

    logic mck = 1'b0;
    logic reset = 1'b0;
    logic din_a = 1'b0;
    logic din_b = 1'b0;

    logic          sck_a, bck_a, lrck_a, rdy_a;
    logic [WA-1:0] dout_a;
    logic [4:0]    cnt_a;
    logic          sck_b, bck_b, lrck_b, rdy_b;
    logic [WB-1:0] dout_b;
    logic [4:0]    cnt_b;

    i2s_rx_core #(.WORD_W(WA), .BCK_DIV_LOG2(LA)) u_a (
        .mck(mck), .reset(reset), .data_in(din_a),
        .sck(sck_a), .bck(bck_a), .lrck(lrck_a),
        .data_out(dout_a), .count(cnt_a), .data_rdy(rdy_a)
    );

    i2s_rx_core #(.WORD_W(WB), .BCK_DIV_LOG2(LB)) u_b (
        .mck(mck), .reset(reset), .data_in(din_b),
        .sck(sck_b), .bck(bck_b), .lrck(lrck_b),
        .data_out(dout_b), .count(cnt_b), .data_rdy(rdy_b)
    );

    always #5 mck = ~mck;

    typedef struct packed {
        logic        lr;
        logic [4:0]  cnt;
        logic        bk;
        logic [31:0] dat;
    } cap_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n        = 0;   // mck rising edges since reset release
    bit   in_rst   = 1'b1;
    logic [31:0] wa [32];
    logic [31:0] ga [32];
    logic [31:0] wb [32];
    logic [31:0] gb [32];
    cap_t qa [$];
    cap_t qb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_tables();
        for (int h = 0; h < 32; h++) begin
            wa[h] = $urandom & 32'h00FF_FFFF;
            ga[h] = $urandom;
            wb[h] = $urandom & 32'h0000_FFFF;
            gb[h] = $urandom;
        end
    endtask

    // Word of the most recent half-frame whose LSB has already been sampled.
    function automatic logic [31:0] exp_word(input int L, input int W, input bit sel_b, input int nn);
        int h;
        int pos;
        int hc;
        h   = nn >> (L + 5);
        pos = nn % (1 << (L + 5));
        hc  = (pos >= W * (1 << L) + (1 << (L - 1))) ? h : h - 1;
        if (hc < 0) return 32'h0;
        return sel_b ? wb[hc % 32] : wa[hc % 32];
    endfunction

    // Serial bit the ADC presents during the slot that edge count nn falls in.
    function automatic logic slot_bit(input int L, input int W, input bit sel_b, input int nn);
        int s;
        int h;
        logic [31:0] w;
        logic [31:0] g;
        s = (nn >> L) & 31;
        h = (nn >> (L + 5)) % 32;
        w = sel_b ? wb[h] : wa[h];
        g = sel_b ? gb[h] : ga[h];
        if (s >= 1 && s <= W) return w[W - s];
        return g[s];
    endfunction

    task automatic check_inst(input string nm, input int L, input int W, input bit sel_b,
                              input logic sck_o, input logic bck_o, input logic lrck_o,
                              input logic [4:0] cnt_o, input logic rdy_o, input logic [31:0] dat_o);
        int div;
        logic [31:0] e_sck, e_bck, e_lrck, e_cnt, e_rdy, e_dat;
        if (in_rst) begin
            e_sck = 0; e_bck = 0; e_lrck = 0; e_cnt = 0; e_rdy = 0; e_dat = 0;
        end else begin
            div    = n % (1 << (L + 6));
            e_sck  = 32'(div & 1);
            e_bck  = 32'((div >> (L - 1)) & 1);
            e_cnt  = 32'((div >> L) & 31);
            e_lrck = 32'((div >> (L + 5)) & 1);
            e_rdy  = 32'((n % (1 << (L + 5))) == W * (1 << L) + (1 << (L - 1)));
            e_dat  = exp_word(L, W, sel_b, n);
        end
        check({nm, ".sck"},      32'(sck_o),  e_sck);
        check({nm, ".bck"},      32'(bck_o),  e_bck);
        check({nm, ".lrck"},     32'(lrck_o), e_lrck);
        check({nm, ".count"},    32'(cnt_o),  e_cnt);
        check({nm, ".data_rdy"}, 32'(rdy_o),  e_rdy);
        check({nm, ".data_out"}, dat_o,       e_dat);
    endtask

    task automatic check_all();
        check_inst("a", LA, WA, 1'b0, sck_a, bck_a, lrck_a, cnt_a, rdy_a, 32'(dout_a));
        check_inst("b", LB, WB, 1'b1, sck_b, bck_b, lrck_b, cnt_b, rdy_b, 32'(dout_b));
    endtask

    task automatic drive();
        din_a = slot_bit(LA, WA, 1'b0, n);
        din_b = slot_bit(LB, WB, 1'b1, n);
    endtask

    task automatic tick();
        @(posedge mck);
        #1;
        if (!in_rst) n++;
        check_all();
        if (rdy_a === 1'b1) qa.push_back('{lr: lrck_a, cnt: cnt_a, bk: bck_a, dat: 32'(dout_a)});
        if (rdy_b === 1'b1) qb.push_back('{lr: lrck_b, cnt: cnt_b, bk: bck_b, dat: 32'(dout_b)});
        drive();
    endtask

    initial begin
        bit found;
        fill_tables();
        wa[0] = 32'h0088_8888;
        wa[1] = 32'h00F0_F0F0;
        wa[2] = 32'h0000_0001;
        ga[1] = 32'hFFFF_FFFF;
        ga[2] = 32'hFFFF_FFFF;
        ga[3] = 32'hFFFF_FFFF;
        wb[0] = 32'h0000_A5A5;

        // Reset held from time zero: everything reads 0 before any edge.
        #1;
        check_all();
        drive();
        repeat (4) tick();

        @(negedge mck);
        reset  = 1'b1;
        in_rst = 1'b0;
        n      = 0;
        drive();
        repeat (6 * 256) tick();

        check("a.strobes", 32'(qa.size()), 32'd6);
        if (qa.size() >= 6) begin
            check("a.w0.dat",  qa[0].dat, 32'h0088_8888);
            check("a.w0.lr",   32'(qa[0].lr), 32'd0);
            check("a.w0.cnt",  32'(qa[0].cnt), 32'd24);
            check("a.w0.bck",  32'(qa[0].bk), 32'd1);
            check("a.w1.dat",  qa[1].dat, 32'h00F0_F0F0);
            check("a.w1.lr",   32'(qa[1].lr), 32'd1);
            check("a.w2.dat",  qa[2].dat, 32'h0000_0001);
            check("a.w2.lr",   32'(qa[2].lr), 32'd0);
            check("a.w3.dat",  qa[3].dat, wa[3]);
            check("a.w5.lr",   32'(qa[5].lr), 32'd1);
        end
        check("b.strobes", 32'(qb.size()), 32'd12);
        if (qb.size() >= 1) begin
            check("b.w0.dat", qb[0].dat, 32'h0000_A5A5);
            check("b.w0.cnt", 32'(qb[0].cnt), 32'd16);
            check("b.w0.lr",  32'(qb[0].lr), 32'd0);
        end

        // Mid-frame reset at count 12 of a left half-frame.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (cnt_a === 5'd12) found = 1'b1;
        end
        check("wait_count12", 32'(found), 32'd1);
        check("a.strobes_pre_reset", 32'(qa.size()), 32'd6);
        #2;
        reset  = 1'b0;
        in_rst = 1'b1;
        #1;
        check_all();

        qa.delete();
        qb.delete();
        fill_tables();
        repeat (3) tick();

        @(negedge mck);
        reset  = 1'b1;
        in_rst = 1'b0;
        n      = 0;
        drive();
        repeat (2 * 256) tick();

        check("a.post_rst.strobes", 32'(qa.size()), 32'd2);
        if (qa.size() >= 2) begin
            check("a.post_rst.w0", qa[0].dat, wa[0]);
            check("a.post_rst.lr0", 32'(qa[0].lr), 32'd0);
            check("a.post_rst.w1", qa[1].dat, wa[1]);
            check("a.post_rst.lr1", 32'(qa[1].lr), 32'd1);
        end
        check("b.post_rst.strobes", 32'(qb.size()), 32'd4);
        if (qb.size() >= 1) begin
            check("b.post_rst.w0", qb[0].dat, wb[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_i2s_rx_core
